// File: rtl/pwm_multichannel.sv
// ============================================================================
//  Module   : pwm_multichannel
//  Brief    : N-channel PWM generator with shared prescaler and period counter,
//             edge/centre-aligned modes, per-channel duty and shadowed,
//             glitch-free period/duty/mode updates. Byte-wide write bus.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_multichannel #(
    parameter int NUM_CH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [5:0]        wr_addr,
    input  logic [7:0]        wr_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start
);

    localparam logic [5:0] c_ADDR_OUT_EN   = 6'h00;
    localparam logic [5:0] c_ADDR_PWM_EN   = 6'h04;
    localparam logic [5:0] c_ADDR_CTRL     = 6'h08;
    localparam logic [5:0] c_ADDR_PRESCALE = 6'h09;
    localparam logic [5:0] c_ADDR_TOP      = 6'h0A;
    localparam logic [5:0] c_ADDR_DUTY     = 6'h10;

    // Counter direction; only centre mode ever leaves DIR_UP
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Programming registers
    logic [NUM_CH-1:0] r_out_en;
    logic [NUM_CH-1:0] r_pwm_en;
    logic              r_mode;
    logic [7:0]        r_prescale;
    logic [7:0]        r_top;
    logic [7:0]        r_duty    [NUM_CH];

    // Shadow copies used by the running period
    logic [7:0]        r_duty_sh [NUM_CH];
    logic [7:0]        r_top_sh;
    logic              r_mode_sh;

    // Timebase
    logic [7:0]        r_psc;
    logic [7:0]        r_cnt;
    dir_t              r_dir;

    logic              w_force;
    logic              w_tick;
    logic              w_wrap;
    logic              w_boundary;
    logic              w_load;
    logic [NUM_CH-1:0] w_cmp;

    assign w_force    = wr_en && (wr_addr == c_ADDR_CTRL) && wr_data[1];
    assign w_tick     = (r_psc == r_prescale);
    assign w_boundary = w_tick && w_wrap;
    assign w_load     = w_boundary || w_force;

    // Decide whether the current count is the last one of the period
    always_comb begin
        w_wrap = 1'b0;
        if (r_top_sh == 8'd0) begin
            w_wrap = 1'b1;
        end else if (!r_mode_sh) begin
            w_wrap = (r_cnt == r_top_sh);
        end else if (r_dir == DIR_UP) begin
            // With TOP=1 the down leg is empty, so the peak itself wraps
            w_wrap = (r_cnt == r_top_sh) && (r_top_sh == 8'd1);
        end else begin
            w_wrap = (r_cnt == 8'd1);
        end
    end

    // Per-channel compare against the shadowed duty
    always_comb begin
        w_cmp = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_cmp[i] = (r_cnt < r_duty_sh[i]);
        end
    end

    // Register file writes; bits and addresses beyond NUM_CH are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_en   <= '0;
            r_pwm_en   <= '0;
            r_mode     <= 1'b0;
            r_prescale <= 8'h00;
            r_top      <= 8'hFF;
            for (int i = 0; i < NUM_CH; i++) begin
                r_duty[i] <= 8'h00;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_addr == c_ADDR_OUT_EN + 6'(i / 8)) begin
                    r_out_en[i] <= wr_data[3'(i % 8)];
                end
                if (wr_addr == c_ADDR_PWM_EN + 6'(i / 8)) begin
                    r_pwm_en[i] <= wr_data[3'(i % 8)];
                end
                if (wr_addr == c_ADDR_DUTY + 6'(i)) begin
                    r_duty[i] <= wr_data;
                end
            end
            case (wr_addr)
                c_ADDR_CTRL:     r_mode     <= wr_data[0];
                c_ADDR_PRESCALE: r_prescale <= wr_data;
                c_ADDR_TOP:      r_top      <= wr_data;
                default: ;
            endcase
        end
    end

    // Prescaler, period counter and direction state machine
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_psc <= 8'd0;
            r_cnt <= 8'd0;
            r_dir <= DIR_UP;
        end else if (w_force) begin
            r_psc <= 8'd0;
            r_cnt <= 8'd0;
            r_dir <= DIR_UP;
        end else begin
            // A PRESCALE lowered below psc lets psc roll over through 255
            r_psc <= w_tick ? 8'd0 : r_psc + 8'd1;
            if (w_tick) begin
                if (w_wrap) begin
                    r_cnt <= 8'd0;
                    r_dir <= DIR_UP;
                end else if (r_dir == DIR_DOWN) begin
                    r_cnt <= r_cnt - 8'd1;
                end else if (r_mode_sh && (r_cnt == r_top_sh)) begin
                    r_cnt <= r_cnt - 8'd1;
                    r_dir <= DIR_DOWN;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end

    // Shadow load at period boundary or FORCE; FORCE takes the CTRL value being written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_top_sh  <= 8'hFF;
            r_mode_sh <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_duty_sh[i] <= 8'h00;
            end
        end else if (w_load) begin
            r_top_sh  <= r_top;
            r_mode_sh <= w_force ? wr_data[0] : r_mode;
            for (int i = 0; i < NUM_CH; i++) begin
                r_duty_sh[i] <= r_duty[i];
            end
        end
    end

    // Registered outputs: channel gating and the period marker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out      <= '0;
            period_start <= 1'b0;
        end else begin
            period_start <= w_load;
            for (int i = 0; i < NUM_CH; i++) begin
                pwm_out[i] <= !r_out_en[i] ? 1'b0 : (!r_pwm_en[i] ? 1'b1 : w_cmp[i]);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pwm_multichannel.sv
// ============================================================================
//  Module   : tb_pwm_multichannel
//  Brief    : Directed self-checking bench for pwm_multichannel.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_multichannel;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [5:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [15:0] pwm_out;
    logic        period_start;
    logic [0:0]  pwm_out1;
    logic        period_start1;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_multichannel #(.NUM_CH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    pwm_multichannel #(.NUM_CH(1)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .pwm_out      (pwm_out1),
        .period_start (period_start1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         n;
        bit         found;
        int         ones;
        int         ones1;
        int         first_ps;
        logic [31:0] v_pwm;
        logic [31:0] v_ps;
        int         exp_cnt [8];

        exp_cnt = '{0, 1, 2, 3, 4, 3, 2, 1};

        // ---------------- Test 1: reset behaviour ----------------
        repeat (3) @(negedge clk);
        check("rst_pwm", 32'(pwm_out), 32'h0);
        check("rst_ps", 32'(period_start), 32'h0);
        @(negedge clk) rst = 1'b0;

        wr(6'h00, 8'h01);              // OUT_EN0, PWM_EN0=0 -> constant high
        repeat (2) @(negedge clk);
        check("t1_high", 32'(pwm_out), 32'h1);

        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t1_async_pwm", 32'(pwm_out), 32'h0);
        check("t1_async_ps", 32'(period_start), 32'h0);
        @(negedge clk) rst = 1'b0;

        n = 0; found = 0;
        while (!found && n < 600) begin
            @(negedge clk); n++;
            if (period_start) found = 1;
        end
        check("t1_first_period", 32'(n), 32'd256);
        n = 0; found = 0;
        while (!found && n < 600) begin
            @(negedge clk); n++;
            if (period_start) found = 1;
        end
        check("t1_period", 32'(n), 32'd256);

        // ---------------- Test 2: edge mode TOP=9 DUTY=3 ----------------
        wr(6'h0A, 8'd9);
        wr(6'h10, 8'd3);
        wr(6'h00, 8'h01);
        wr(6'h04, 8'h01);
        wr(6'h08, 8'h02);
        v_pwm = '0; v_ps = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            v_pwm[k] = pwm_out[0];
            v_ps[k]  = period_start;
        end
        check("t2_pwm", v_pwm, 32'h380E);
        check("t2_ps", v_ps, 32'h401);

        // ---------------- Test 3: enables and duty extremes ----------------
        wr(6'h00, 8'h21);
        repeat (2) @(negedge clk);
        check("t3_ch5_on", 32'(pwm_out[5]), 32'h1);
        wr(6'h00, 8'h01);
        @(negedge clk);
        check("t3_ch5_lat", 32'(pwm_out[5]), 32'h1);
        @(negedge clk);
        check("t3_ch5_off", 32'(pwm_out[5]), 32'h0);

        wr(6'h10, 8'd0);
        wr(6'h08, 8'h02);
        @(negedge clk);
        ones = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            ones += int'(pwm_out[0]);
        end
        check("t3_duty0", 32'(ones), 32'd0);

        wr(6'h10, 8'd10);
        wr(6'h08, 8'h02);
        @(negedge clk);
        ones = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            ones += int'(pwm_out[0]);
        end
        check("t3_duty_over", 32'(ones), 32'd20);

        // ---------------- Test 4: centre mode TOP=4 DUTY=2 ----------------
        wr(6'h0A, 8'd4);
        wr(6'h10, 8'd2);
        wr(6'h08, 8'h03);
        @(negedge clk);
        check("t4_cnt0", 32'(dut.r_cnt), 32'(exp_cnt[0]));
        v_pwm = '0; v_ps = '0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            v_pwm[k-1] = pwm_out[0];
            v_ps[k-1]  = period_start;
            if (k < 8) check("t4_cnt", 32'(dut.r_cnt), 32'(exp_cnt[k]));
        end
        check("t4_pwm", v_pwm, 32'h8383);
        check("t4_ps", v_ps, 32'h8080);

        // ---------------- Test 5: shadowed duty update ----------------
        wr(6'h0A, 8'd9);
        wr(6'h10, 8'd3);
        wr(6'h08, 8'h02);
        wr(6'h10, 8'd7);               // lands one cycle into the period
        v_pwm = '0; v_ps = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            v_pwm[k-1] = pwm_out[0];
            v_ps[k-1]  = period_start;
        end
        check("t5_mid_pwm", v_pwm, 32'h1FC07);
        check("t5_mid_ps", v_ps, 32'h80200);

        // Now sitting just after a boundary; next write lands on the next boundary edge
        repeat (8) @(negedge clk);
        wr(6'h10, 8'd2);
        v_pwm = '0; v_ps = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            v_pwm[k] = pwm_out[0];
            v_ps[k]  = period_start;
        end
        check("t5_bnd_pwm", v_pwm, 32'h18FE);
        check("t5_bnd_ps", v_ps, 32'h401);

        // ---------------- Test 6: prescaler and NUM_CH=1 ----------------
        wr(6'h09, 8'd1);
        wr(6'h08, 8'h02);
        @(negedge clk);
        check("t6_ps0", 32'(period_start), 32'h1);
        ones = 0; ones1 = 0; first_ps = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            ones  += int'(pwm_out[0]);
            ones1 += int'(pwm_out1[0]);
            if (k == 5) check("t6_cnt_k5", 32'(dut.r_cnt), 32'd2);
            if (period_start && first_ps == 0) first_ps = k;
        end
        check("t6_period", 32'(first_ps), 32'd20);
        check("t6_high", 32'(ones), 32'd4);
        check("t6_high_n1", 32'(ones1), 32'd4);

        wr(6'h11, 8'd9);               // DUTY[1] does not exist when NUM_CH=1
        wr(6'h08, 8'h02);
        @(negedge clk);
        ones1 = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            ones1 += int'(pwm_out1[0]);
        end
        check("t6_n1_ignore", 32'(ones1), 32'd4);
        check("t6_ch1_off", 32'(pwm_out[1]), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
